axi_rd_responder: RTL
=====================

Name: axi_rd_responder

Overview:
AXI4 read-channel responder (slave end) backed by an internal word-addressed SRAM array. It sits downstream of the icache/LSU read arbiter and serves both single-beat LSU reads and INCR/WRAP icache line fills. A simple backdoor write port lets the testbench or simulation loader fill the memory. It provides the read-data-side counterpart that the arbiter forwards requests to.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width; fixed at 32 in this revision
MEM_WORDS, 1024, SRAM depth in 32-bit words; power of two
BASE_ADDR, 32'h8000_0000, byte address of word 0
RD_LATENCY, 1, cycles from AR handshake to first rvalid; legal range 1..15

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
araddr  in  ADDR_W  read start byte address
arvalid  in  1  AR valid
arready  out  1  AR ready
arlen  in  8  beats minus one
arsize  in  3  log2 bytes per beat
arburst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
rdata  out  DATA_W  read data
rresp  out  2  00 OKAY, 10 SLVERR, 11 DECERR
rvalid  out  1  R valid
rready  in  1  R ready
rlast  out  1  final beat marker
bd_we  in  1  backdoor write enable
bd_addr  in  ADDR_W  backdoor byte address, word-aligned
bd_wdata  in  32  backdoor write data
bd_wstrb  in  4  backdoor byte strobes

Behaviour:
- Reset: all registers cleared. While rst is high: arready=0, rvalid=0, rlast=0, rresp=00, rdata=0. State goes to IDLE. Memory contents are not cleared.
- FSM states:
  - IDLE: arready=1. On arvalid&&arready, latch addr, len, size and burst, set beat_cnt=0, and go to WAIT. If RD_LATENCY==1, go directly to SEND with beat 0 loaded.
  - WAIT: counts RD_LATENCY-1 cycles, then loads beat 0 and goes to SEND.
  - SEND: rvalid=1.
    - On rvalid&&rready with beat_cnt==len: go to IDLE, and arready rises in the following cycle.
    - On rvalid&&rready otherwise: load the next beat in the same edge, so there is no bubble with rready held high.
- arready is 0 in WAIT and SEND. Only one outstanding transaction is allowed.
- Latency: the first rvalid is high exactly RD_LATENCY cycles after the AR handshake edge.
- Beat loading:
  - rdata, rresp and rlast are registered when a beat is loaded.
  - They are held stable while rvalid&&!rready.
  - rlast = (beat_cnt==len).
- Address generation, with step = 1<<size:
  - FIXED: the address never changes.
  - INCR: addr += step.
  - WRAP: boundary = (len+1)*step. Next address = (addr & ~(boundary-1)) | ((addr+step) & (boundary-1)).
- Word index = (addr-BASE_ADDR)>>2. The full aligned word is returned; the initiator selects the lanes for narrow reads.
- Error rules, evaluated per beat. All beats are still delivered, with rdata=0, and rlast is still correct.
  - addr outside [BASE_ADDR, BASE_ADDR+4*MEM_WORDS): DECERR.
  - arsize>2, arburst==11, or WRAP with len not in {1,3,7,15}: SLVERR on every beat.
- Backdoor writes:
  - A backdoor write takes effect at the clock edge. Strobed bytes only; out-of-range writes are ignored.
  - A write coincident with a beat load to the same word: the loaded beat carries the old data.
  - A beat already held on rdata is unaffected by later writes.
- Reset mid-burst: the transaction is aborted and no further beats are issued. rvalid drops in the reset cycle.
- len=255 INCR: beat_cnt must be 8 bits and exit exactly after 256 beats. 4KB crossing is the initiator's responsibility; this block does not check it.

Decomposition:
- Shared package axi_pkg:
  - Burst encodings: BURST_FIXED, BURST_INCR, BURST_WRAP.
  - Response encodings: RESP_OKAY, RESP_SLVERR, RESP_DECERR.
  - FSM state typedef: IDLE, WAIT, SEND.
- One sub-module, axi_burst_addr_gen: a combinational next-address and legality check taking addr, len, size and burst, returning next_addr and burst_err. It is reused later by the write responder.

Test Plan:
- Preload word 0 = 0xDEADBEEF. AR addr=0x8000_0000, len=0, size=2, INCR, rready=1, RD_LATENCY=1 -> rvalid one cycle after handshake, rdata=0xDEADBEEF, rresp=00, rlast=1, arready=1 next cycle.
- Preload words 0..3 = 0x10,0x11,0x12,0x13. INCR len=3 from 0x8000_0000 with rready toggling 1,0,0,1 -> data 0x10..0x13 in order, held stable while stalled, rlast only on the 4th beat.
- WRAP len=3, size=2, addr=0x8000_000C -> addresses 0C,00,04,08; data = words 3,0,1,2; all OKAY.
- AR addr=0x9000_0000, INCR len=1 -> two beats, rresp=11, rdata=0, rlast on the 2nd; arburst=11 or WRAP len=2 -> SLVERR on all beats.
- RD_LATENCY=4: AR handshake at cycle N -> first rvalid at N+4; FIXED len=2 at word 5 -> three beats of word 5.
- Assert rst during beat 2 of an INCR len=7 burst -> rvalid=0 in the reset cycle; after reset, arready=1 and no stale beats; a new single read completes normally.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI read/write responder encodings, FSM state type and the registered R-beat bundle.
package axi_pkg;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        SEND
    } state_t;

    typedef struct packed {
        logic [31:0] dat;
        logic [1:0]  resp;
        logic        last;
    } rbeat_t;

    // Wrapping bursts are only legal with 2, 4, 8 or 16 beats.
    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction
endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational AXI burst next-address generator and burst legality check.
// Zero latency; no flow control, shared by the read and write responders.
module axi_burst_addr_gen
    import axi_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [7:0]        i_len,
    input  logic [2:0]        i_size,
    input  logic [1:0]        i_burst,
    output logic [ADDR_W-1:0] o_next_addr,
    output logic              o_burst_err
);

    logic [ADDR_W-1:0] w_step;
    logic [ADDR_W-1:0] w_incr;
    logic [ADDR_W-1:0] w_wrap_mask;

    assign w_step      = ADDR_W'(1) << i_size;
    assign w_incr      = i_addr + w_step;
    // (len+1)*step is a power of two whenever the wrap length is legal
    assign w_wrap_mask = ((ADDR_W'(i_len) + ADDR_W'(1)) << i_size) - ADDR_W'(1);

    always_comb begin
        o_next_addr = w_incr;
        case (i_burst)
            BURST_FIXED: o_next_addr = i_addr;
            BURST_INCR:  o_next_addr = w_incr;
            BURST_WRAP:  o_next_addr = (i_addr & ~w_wrap_mask) | (w_incr & w_wrap_mask);
            default:     o_next_addr = w_incr;
        endcase
    end

    always_comb begin
        o_burst_err = 1'b0;
        if (i_size > 3'd2)
            o_burst_err = 1'b1;
        if (i_burst == BURST_RSVD)
            o_burst_err = 1'b1;
        if ((i_burst == BURST_WRAP) && !wrap_len_ok(i_len))
            o_burst_err = 1'b1;
    end

endmodule

// File: rtl/axi_rd_responder.sv
// AXI4 read responder over an internal SRAM with a backdoor fill port; one burst outstanding.
// First beat RD_LATENCY cycles after AR; beats stay registered and stable while rready is low.
module axi_rd_responder
    import axi_pkg::*;
#(
    parameter int unsigned       ADDR_W     = 32,
    parameter int unsigned       DATA_W     = 32,
    parameter int unsigned       MEM_WORDS  = 1024,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'h8000_0000,
    parameter int unsigned       RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] araddr,
    input  logic              arvalid,
    output logic              arready,
    input  logic [7:0]        arlen,
    input  logic [2:0]        arsize,
    input  logic [1:0]        arburst,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        rresp,
    output logic              rvalid,
    input  logic              rready,
    output logic              rlast,
    input  logic              bd_we,
    input  logic [ADDR_W-1:0] bd_addr,
    input  logic [31:0]       bd_wdata,
    input  logic [3:0]        bd_wstrb
);

    localparam int unsigned       IDX_W     = $clog2(MEM_WORDS);
    localparam logic [ADDR_W-1:0] MEM_BYTES = ADDR_W'(MEM_WORDS) << 2;
    localparam logic [3:0]        LAT_INIT  = (RD_LATENCY > 1) ? 4'(RD_LATENCY - 2) : 4'd0;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_len;
    logic [2:0]        r_size;
    logic [1:0]        r_burst;
    logic              r_err;
    logic [7:0]        r_beat_cnt;
    logic [3:0]        r_lat_cnt;
    rbeat_t            r_beat;

    logic [DATA_W-1:0] r_mem [MEM_WORDS];

    logic              w_ar_hs;
    logic              w_r_hs;
    logic              w_last_hs;
    logic              w_wait_done;

    logic [ADDR_W-1:0] w_ag_addr;
    logic [7:0]        w_ag_len;
    logic [2:0]        w_ag_size;
    logic [1:0]        w_ag_burst;
    logic [ADDR_W-1:0] w_next_addr;
    logic              w_burst_err;

    logic              w_load;
    logic [ADDR_W-1:0] w_ld_addr;
    logic              w_ld_err;
    logic [7:0]        w_ld_cnt;
    logic [7:0]        w_ld_len;
    logic [ADDR_W-1:0] w_ld_off;
    logic              w_ld_in_rng;
    logic [IDX_W-1:0]  w_ld_idx;
    rbeat_t            w_beat;

    logic [ADDR_W-1:0] w_bd_off;
    logic              w_bd_in_rng;
    logic [IDX_W-1:0]  w_bd_idx;

    assign w_ar_hs     = arvalid && arready;
    assign w_r_hs      = rvalid && rready;
    assign w_last_hs   = w_r_hs && (r_beat_cnt == r_len);
    assign w_wait_done = (r_state == WAIT) && (r_lat_cnt == 4'd0);

    // While idle the generator checks the incoming AR; afterwards it steps the latched burst.
    always_comb begin
        w_ag_addr  = r_addr;
        w_ag_len   = r_len;
        w_ag_size  = r_size;
        w_ag_burst = r_burst;
        if (r_state == IDLE) begin
            w_ag_addr  = araddr;
            w_ag_len   = arlen;
            w_ag_size  = arsize;
            w_ag_burst = arburst;
        end
    end

    axi_burst_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .i_addr      (w_ag_addr),
        .i_len       (w_ag_len),
        .i_size      (w_ag_size),
        .i_burst     (w_ag_burst),
        .o_next_addr (w_next_addr),
        .o_burst_err (w_burst_err)
    );

    always_comb begin
        w_load    = 1'b0;
        w_ld_addr = r_addr;
        w_ld_err  = r_err;
        w_ld_cnt  = 8'd0;
        w_ld_len  = r_len;
        case (r_state)
            IDLE: begin
                w_load    = w_ar_hs && (RD_LATENCY == 1);
                w_ld_addr = araddr;
                w_ld_err  = w_burst_err;
                w_ld_len  = arlen;
            end
            WAIT: begin
                w_load = w_wait_done;
            end
            SEND: begin
                w_load    = w_r_hs && !w_last_hs;
                w_ld_addr = w_next_addr;
                w_ld_cnt  = r_beat_cnt + 8'd1;
            end
            default: ;
        endcase
    end

    assign w_ld_off    = w_ld_addr - BASE_ADDR;
    assign w_ld_in_rng = w_ld_off < MEM_BYTES;
    assign w_ld_idx    = w_ld_off[IDX_W+1:2];

    // Memory is read before any same-edge backdoor write lands, so a coincident load sees old data.
    always_comb begin
        w_beat      = '0;
        w_beat.last = (w_ld_cnt == w_ld_len);
        if (w_ld_err)
            w_beat.resp = RESP_SLVERR;
        else if (!w_ld_in_rng)
            w_beat.resp = RESP_DECERR;
        else begin
            w_beat.resp = RESP_OKAY;
            w_beat.dat  = 32'(r_mem[w_ld_idx]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_ar_hs) w_state_nxt = (RD_LATENCY == 1) ? SEND : WAIT;
            WAIT:    if (w_wait_done) w_state_nxt = SEND;
            SEND:    if (w_last_hs) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Outputs are forced quiet for the whole reset cycle, not just after the reset edge.
    always_comb begin
        arready = !rst && (r_state == IDLE);
        rvalid  = !rst && (r_state == SEND);
        rdata   = rst ? '0 : DATA_W'(r_beat.dat);
        rresp   = rst ? RESP_OKAY : r_beat.resp;
        rlast   = !rst && r_beat.last;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr     <= '0;
            r_len      <= '0;
            r_size     <= '0;
            r_burst    <= '0;
            r_err      <= 1'b0;
            r_beat_cnt <= '0;
            r_lat_cnt  <= '0;
            r_beat     <= '0;
        end else begin
            if ((r_state == IDLE) && w_ar_hs) begin
                r_addr     <= araddr;
                r_len      <= arlen;
                r_size     <= arsize;
                r_burst    <= arburst;
                r_err      <= w_burst_err;
                r_beat_cnt <= 8'd0;
                r_lat_cnt  <= LAT_INIT;
            end else if ((r_state == WAIT) && (r_lat_cnt != 4'd0)) begin
                r_lat_cnt <= r_lat_cnt - 4'd1;
            end
            if ((r_state == SEND) && w_r_hs && !w_last_hs) begin
                r_addr     <= w_next_addr;
                r_beat_cnt <= r_beat_cnt + 8'd1;
            end
            if (w_load)
                r_beat <= w_beat;
        end
    end

    assign w_bd_off    = bd_addr - BASE_ADDR;
    assign w_bd_in_rng = w_bd_off < MEM_BYTES;
    assign w_bd_idx    = w_bd_off[IDX_W+1:2];

    always_ff @(posedge clk) begin
        if (bd_we && w_bd_in_rng) begin
            for (int b = 0; b < 4; b++) begin
                if (bd_wstrb[b])
                    r_mem[w_bd_idx][8*b +: 8] <= bd_wdata[8*b +: 8];
            end
        end
    end

endmodule
